// File: rtl/cond_sum_adder_pipe.sv
// Pipelined conditional-sum adder/subtractor with a valid/ready stream interface.
// Level 0 forms per-bit candidate pairs; each merge level doubles the resolved block size.
module cond_sum_adder_pipe #(
    parameter int WIDTH = 8,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    logic             adv;
    logic [LOG2W:0]   vld_reg;
    logic [LOG2W:0]   xm_reg;
    logic [LOG2W:0]   ym_reg;
    logic [WIDTH-1:0] y_inv;
    logic             c_in0;

    assign y_inv     = y ^ {WIDTH{sub}};
    assign c_in0     = sub | cin;
    assign adv       = !vld_reg[LOG2W] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_reg[LOG2W];

    // Valid and operand sign bits ride alongside the beat through every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_reg <= '0;
            xm_reg  <= '0;
            ym_reg  <= '0;
        end else if (adv) begin
            vld_reg <= {vld_reg[LOG2W-1:0], in_valid};
            xm_reg  <= {xm_reg[LOG2W-1:0], x[WIDTH-1]};
            ym_reg  <= {ym_reg[LOG2W-1:0], y_inv[WIDTH-1]};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi <= LOG2W; gi++) begin : lvl
            localparam int NB = WIDTH >> gi;
            // Candidate assuming block carry-in 0 (block 0 holds the resolved value).
            logic [WIDTH-1:0] s0_next, s0_reg;
            logic [NB-1:0]    c0_next, c0_reg;

            if (gi == 0) begin : g_sel
                always_comb begin
                    s0_next    = x ^ y_inv;
                    c0_next    = x & y_inv;
                    s0_next[0] = x[0] ^ y_inv[0] ^ c_in0;
                    c0_next[0] = (x[0] & y_inv[0]) | (c_in0 & (x[0] ^ y_inv[0]));
                end
            end else begin : g_sel
                localparam int BS = 1 << gi;
                localparam int H  = BS / 2;
                always_comb begin
                    s0_next = '0;
                    c0_next = '0;
                    for (int b = 0; b < NB; b++) begin
                        s0_next[b*BS +: H] = lvl[gi-1].s0_reg[b*BS +: H];
                        if (lvl[gi-1].c0_reg[2*b]) begin
                            s0_next[b*BS+H +: H] = lvl[gi-1].g_cand.s1_reg[b*BS+H +: H];
                            c0_next[b]           = lvl[gi-1].g_cand.c1_reg[2*b+1];
                        end else begin
                            s0_next[b*BS+H +: H] = lvl[gi-1].s0_reg[b*BS+H +: H];
                            c0_next[b]           = lvl[gi-1].c0_reg[2*b+1];
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s0_reg <= '0;
                    c0_reg <= '0;
                end else if (adv) begin
                    s0_reg <= s0_next;
                    c0_reg <= c0_next;
                end
            end

            // The carry-in-1 candidate is not needed once the word is fully resolved.
            if (gi < LOG2W) begin : g_cand
                logic [WIDTH-1:0] s1_next, s1_reg;
                logic [NB-1:0]    c1_next, c1_reg;

                if (gi == 0) begin : g_c
                    always_comb begin
                        s1_next    = ~(x ^ y_inv);
                        c1_next    = x | y_inv;
                        s1_next[0] = x[0] ^ y_inv[0] ^ c_in0;
                        c1_next[0] = (x[0] & y_inv[0]) | (c_in0 & (x[0] ^ y_inv[0]));
                    end
                end else begin : g_c
                    localparam int BS = 1 << gi;
                    localparam int H  = BS / 2;
                    always_comb begin
                        s1_next = '0;
                        c1_next = '0;
                        for (int b = 0; b < NB; b++) begin
                            s1_next[b*BS +: H] = lvl[gi-1].g_cand.s1_reg[b*BS +: H];
                            if (lvl[gi-1].g_cand.c1_reg[2*b]) begin
                                s1_next[b*BS+H +: H] = lvl[gi-1].g_cand.s1_reg[b*BS+H +: H];
                                c1_next[b]           = lvl[gi-1].g_cand.c1_reg[2*b+1];
                            end else begin
                                s1_next[b*BS+H +: H] = lvl[gi-1].s0_reg[b*BS+H +: H];
                                c1_next[b]           = lvl[gi-1].c0_reg[2*b+1];
                            end
                        end
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        s1_reg <= '0;
                        c1_reg <= '0;
                    end else if (adv) begin
                        s1_reg <= s1_next;
                        c1_reg <= c1_next;
                    end
                end
            end
        end
    endgenerate

    assign s    = lvl[LOG2W].s0_reg;
    assign cout = lvl[LOG2W].c0_reg[0];
    assign ovf  = (xm_reg[LOG2W] == ym_reg[LOG2W]) && (s[WIDTH-1] != xm_reg[LOG2W]);

endmodule

// File: tb/tb_cond_sum_adder_pipe.sv
// Scoreboard bench for cond_sum_adder_pipe: directed WIDTH=8 cases plus a random WIDTH=16 run.
module tb_cond_sum_adder_pipe;

    localparam int L8  = 4;
    localparam int L16 = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v8 = 0, r8, cin8 = 0, sub8 = 0, ov8, ordy8 = 1, co8, of8;
    logic [7:0]  x8 = 0, y8 = 0, s8;
    logic        v16 = 0, r16, cin16 = 0, sub16 = 0, ov16, ordy16 = 1, co16, of16;
    logic [15:0] x16 = 0, y16 = 0, s16;

    cond_sum_adder_pipe #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .x(x8), .y(y8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(ordy8),
        .s(s8), .cout(co8), .ovf(of8)
    );

    cond_sum_adder_pipe #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .x(x16), .y(y16),
        .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(ordy16),
        .s(s16), .cout(co16), .ovf(of16)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_in16 = 0;
    int n_out16 = 0;
    bit chk_lat = 1'b1;
    logic [17:0] q8[$];
    logic [17:0] q16[$];
    int t8[$];
    bit hold8 = 0, hold16 = 0;
    logic [17:0] held8, held16;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic, result packed as {ovf, cout, s}.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint m = longint'(1) << w;
        longint half = m >> 1;
        longint sum, sa, sbv, sr;
        logic co, ov;
        logic [15:0] sv;
        if (sb) begin
            sum = ua - ub;
            co  = (ua >= ub);
        end else begin
            sum = ua + ub + longint'(ci);
            co  = (sum >= m);
        end
        sum = (sum + m) % m;
        sa  = (ua >= half) ? ua - m : ua;
        sbv = (ub >= half) ? ub - m : ub;
        sr  = sb ? (sa - sbv) : (sa + sbv + longint'(ci));
        ov  = (sr >= half) || (sr < -half);
        sv  = 16'(sum);
        return {ov, co, sv};
    endfunction

    task automatic drive8(input bit v, input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic sb, input bit ordy, output bit acc);
        @(negedge clk);
        v8 = v; x8 = a; y8 = b; cin8 = ci; sub8 = sb; ordy8 = ordy;
        #1;
        acc = v && r8 && !rst;
        if (acc) begin
            q8.push_back(model(8, {8'h00, a}, {8'h00, b}, ci, sb));
            t8.push_back(cyc);
            $display("in8  x=%02h y=%02h cin=%0d sub=%0d", a, b, ci, sb);
        end
    endtask

    task automatic drive16(input bit v, input logic [15:0] a, input logic [15:0] b, input logic ci,
                           input logic sb, input bit ordy);
        @(negedge clk);
        v16 = v; x16 = a; y16 = b; cin16 = ci; sub16 = sb; ordy16 = ordy;
        #1;
        if (v && r16 && !rst) begin
            q16.push_back(model(16, a, b, ci, sb));
            n_in16++;
        end
    endtask

    task automatic drain8();
        bit acc;
        for (int i = 0; i < 20 && q8.size() != 0; i++) drive8(0, 8'h00, 8'h00, 0, 0, 1, acc);
        check("drain8_pending", q8.size(), 0);
    endtask

    // Monitor: pops the scoreboard whenever a result is handed off downstream.
    initial begin
        logic [17:0] e;
        int t;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold8 = 0;
                hold16 = 0;
            end else begin
                if (hold8) begin
                    check("hold8_valid", ov8, 1);
                    check("hold8_data", {of8, co8, s8}, held8[9:0]);
                end
                hold8 = 0;
                if (ov8 && !ordy8) begin
                    check("stall8_in_ready", r8, 0);
                    hold8 = 1;
                    held8 = {8'h00, of8, co8, s8};
                end
                if (ov8 && ordy8) begin
                    if (q8.size() == 0) check("out8_spurious", ov8, 0);
                    else begin
                        e = q8.pop_front();
                        t = t8.pop_front();
                        $display("out8 s=%02h cout=%0d ovf=%0d", s8, co8, of8);
                        check("out8_result", {of8, co8, 8'h00, s8}, e);
                        if (chk_lat) check("out8_latency", cyc - t, L8);
                    end
                end

                if (hold16) begin
                    check("hold16_valid", ov16, 1);
                    check("hold16_data", {of16, co16, s16}, held16);
                end
                hold16 = 0;
                if (ov16 && !ordy16) begin
                    check("stall16_in_ready", r16, 0);
                    hold16 = 1;
                    held16 = {of16, co16, s16};
                end
                if (ov16 && ordy16) begin
                    if (q16.size() == 0) check("out16_spurious", ov16, 0);
                    else begin
                        e = q16.pop_front();
                        n_out16++;
                        $display("out16 s=%04h cout=%0d ovf=%0d", s16, co16, of16);
                        check("out16_result", {of16, co16, s16}, e);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        check("reset_out_valid8", ov8, 0);
        check("reset_s8", s8, 0);
        check("reset_cout8", co8, 0);
        check("reset_ovf8", of8, 0);
        check("reset_in_ready8", r8, 1);
        check("reset_out_valid16", ov16, 0);

        // Wrap-around with carry out.
        drive8(1, 8'hFF, 8'h01, 0, 0, 1, acc);
        drain8();

        // Subtract with borrow, then signed overflow, back to back.
        drive8(1, 8'h05, 8'h07, 0, 1, 1, acc);
        drive8(1, 8'h7F, 8'h01, 0, 0, 1, acc);
        drain8();

        // Carry-in ripples through every merge level.
        drive8(1, 8'hAA, 8'h55, 1, 0, 1, acc);
        drain8();

        // Backpressure: out_ready low on cycles 5..8.
        chk_lat = 0;
        n = 1;
        for (int c = 1; c <= 30; c++) begin
            drive8(n <= 6, 8'(n), 8'(n), 0, 0, !(c >= 5 && c <= 8), acc);
            if (acc) n++;
        end
        check("bp_beats_accepted", n, 7);
        drain8();

        // Reset with three beats in flight; a beat offered during reset is refused.
        chk_lat = 1;
        for (int i = 1; i <= 3; i++) drive8(1, 8'(i), 8'(i), 0, 0, 1, acc);
        @(negedge clk);
        rst = 1; v8 = 1; x8 = 8'h77; y8 = 8'h11;
        q8.delete();
        t8.delete();
        @(negedge clk);
        rst = 0; v8 = 0;
        #1;
        check("midrst_out_valid", ov8, 0);
        check("midrst_in_ready", r8, 1);
        drive8(1, 8'h10, 8'h20, 0, 0, 1, acc);
        for (int i = 0; i < 8; i++) drive8(0, 8'h00, 8'h00, 0, 0, 1, acc);
        check("midrst_pending", q8.size(), 0);

        // Random WIDTH=16 regression with random backpressure.
        for (int i = 0; i < 20000 && n_in16 < 1000; i++)
            drive16($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        check("rand16_beats_in", n_in16, 1000);
        for (int i = 0; i < 4 * L16 && q16.size() != 0; i++) drive16(0, 16'h0, 16'h0, 0, 0, 1);
        check("rand16_beats_out", n_out16, n_in16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cond_sum_adder_pipe.md
Name: cond_sum_adder_pipe

Overview:
- Parametrised, pipelined conditional-sum adder/subtractor: the registered, width-generic successor to the combinational 8-bit conditional-sum adder.
- Level 0 forms per-bit sum/carry pairs for assumed carry 0 and carry 1.
- Each of log2(WIDTH) merge levels uses the lower block's resolved carry to select the upper block's pair, doubling block size.
- One register stage per level, with a valid/ready stream interface so it drops into datapaths that apply backpressure.

Parameters:
- WIDTH, 8, operand width; power of two, >= 2.
- LOG2W, $clog2(WIDTH), number of merge levels; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- x  input  WIDTH  operand X.
- y  input  WIDTH  operand Y.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  1 = compute X - Y (Y inverted, carry-in forced to 1).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  sum or difference.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Pipeline depth L = LOG2W + 1 register stages; L = 4 for WIDTH=8.
- Level 0 registers, per bit i:
  - Y' = y ^ {WIDTH{sub}}; c0 = sub ? 1 : cin.
  - Bit 0 uses the real carry c0 and is resolved immediately.
  - Bits 1..WIDTH-1 hold both candidate pairs: {s0, c0} = x_i + y'_i + 0 and {s1, c1} = x_i + y'_i + 1.
- Merge level k (k = 1..LOG2W), on blocks of size 2^k:
  - The lower half's carry (resolved, or per-candidate) selects the upper half's candidate sum and carry.
  - The lowest block is always resolved.
  - After level LOG2W the whole word is resolved and registered into s and cout.
- Sign bits: x[WIDTH-1] and y'[WIDTH-1] travel with the beat through every stage. ovf = (xm == ym) && (s[WIDTH-1] != xm).
- Each stage carries a valid bit; the output stage valid bit drives out_valid.
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - On adv, every stage loads from the previous stage, including its valid bit.
  - Stage 0 loads in_valid && in_ready.
  - When adv = 0, every stage, including the outputs, holds its value.
- Stage valid bits at output: bubbles propagate as valid=0; s, cout and ovf are don't-care while out_valid=0.
- Throughput is one beat per cycle when out_ready is held at 1; first result appears L cycles after acceptance.
- out_ready = 0 while out_valid = 1:
  - s, cout, ovf and out_valid must stay stable.
  - in_ready = 0.
  - No beat is lost or duplicated.
- Simultaneous out_ready = 1 and in_valid = 1 with a full pipe: accept and emit in the same cycle.
- Reset (sync, any time, including mid-stream):
  - Values: all stage valid bits = 0; s = 0, cout = 0, ovf = 0, out_valid = 0.
  - in_ready reads 1 in the cycle after reset deasserts.
  - Beats in flight are discarded.
  - A beat presented during a cycle with rst = 1 is not accepted.
- Wrap-around: the sum is modulo 2^WIDTH; carry out is reported on cout only.

Test Plan:
- WIDTH=8, out_ready=1, single beat x=0xFF, y=0x01, cin=0, sub=0 -> 4 cycles later out_valid=1, s=0x00, cout=1, ovf=0.
- Subtract and overflow, in back-to-back cycles:
  - x=0x05, y=0x07, sub=1 -> s=0xFE, cout=0, ovf=0.
  - then x=0x7F, y=0x01, cin=0 -> s=0x80, cout=0, ovf=1.
  - Results appear on consecutive cycles.
- Carry-in through the full chain: x=0xAA, y=0x55, cin=1 -> s=0x00, cout=1; confirms the resolved carry selects at every merge level.
- Backpressure:
  - Stream 6 beats of x=n, y=n (n = 1..6) with out_ready low for cycles 5..8.
  - Outputs held stable and in_ready=0 while stalled.
  - Results 2, 4, 6, 8, 10, 12 delivered in order, none dropped.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> out_valid=0 the next cycle, none of those 3 beats emerge, a new beat 0x10+0x20 yields s=0x30 after 4 cycles.
- WIDTH=16 regression (L=5): 1000 random x, y, cin, sub beats with random out_ready -> match the reference model (x ± y ± cin) for s, cout and ovf; beat count in equals beat count out.
